// File: rtl/register_file_pkg.sv
// Shared processor package: datapath widths and the register-file size constant.
// Any block that instantiates the register file pulls its defaults from here.
package register_file_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_NUM_REGS = 2 ** DEFAULT_ADDR_W;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// General-purpose register file.
// Two combinational read ports (X, Y), one clocked write port (Z), synchronous active-high reset.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_wr,
  input  logic [ADDR_W-1:0] addr_Rx,
  input  logic [ADDR_W-1:0] addr_Ry,
  input  logic [ADDR_W-1:0] addr_Rz,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] Rx_value,
  output logic [DATA_W-1:0] Ry_value
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // NOTE: start from the current contents so every element has a value on
  // every path; a partial update here would otherwise infer latches.
  always_comb begin
    regs_d = regs_q;
    if (reg_wr) begin
      regs_d[addr_Rz] = write_data;
    end
  end

  // NOTE: the storage array is reset on purpose -- the processor relies on
  // every register reading zero after reset -- and reset beats any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the flops: no write-to-read bypass.
  assign Rx_value = regs_q[addr_Rx];
  assign Ry_value = regs_q[addr_Ry];

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Inputs change 1ns after a rising edge; outputs are sampled mid-cycle.
module tb_register_file;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              reset;
  logic              reg_wr;
  logic [ADDR_W-1:0] addr_Rx;
  logic [ADDR_W-1:0] addr_Ry;
  logic [ADDR_W-1:0] addr_Rz;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] Rx_value;
  logic [DATA_W-1:0] Ry_value;

  int checks   = 0;
  int failures = 0;

  register_file #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_wr    (reg_wr),
    .addr_Rx   (addr_Rx),
    .addr_Ry   (addr_Ry),
    .addr_Rz   (addr_Rz),
    .write_data(write_data),
    .Rx_value  (Rx_value),
    .Ry_value  (Ry_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] observed,
                       input logic [DATA_W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    reg_wr     = 1'b1;
    addr_Rz    = a;
    write_data = d;
    tick();
    reg_wr     = 1'b0;
  endtask

  task automatic read_both(input logic [ADDR_W-1:0] ax, input logic [ADDR_W-1:0] ay);
    addr_Rx = ax;
    addr_Ry = ay;
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    reg_wr     = 1'b0;
    addr_Rx    = '0;
    addr_Ry    = '0;
    addr_Rz    = '0;
    write_data = '0;

    // Reset for two cycles, then every address reads zero on both ports.
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      read_both(i[ADDR_W-1:0], 4'(15 - i));
      check($sformatf("rst_rx_r%0d", i), Rx_value, 16'h0000);
      check($sformatf("rst_ry_r%0d", 15 - i), Ry_value, 16'h0000);
    end

    // Back-to-back writes to different registers.
    do_write(4'd1, 16'hAAAA);
    do_write(4'd2, 16'h5555);
    read_both(4'd1, 4'd2);
    check("wr_r1_rx", Rx_value, 16'hAAAA);
    check("wr_r2_ry", Ry_value, 16'h5555);

    // Write enable low: addressed register must not change.
    reg_wr     = 1'b0;
    addr_Rz    = 4'd3;
    write_data = 16'h1234;
    tick();
    tick();
    tick();
    read_both(4'd3, 4'd1);
    check("nowr_r3", Rx_value, 16'h0000);
    check("nowr_r1_intact", Ry_value, 16'hAAAA);

    // Read during write: old value before the edge, new value right after.
    read_both(4'd5, 4'd5);
    reg_wr     = 1'b1;
    addr_Rz    = 4'd5;
    write_data = 16'hBEEF;
    #1;
    check("rdw_before_rx", Rx_value, 16'h0000);
    check("rdw_before_ry", Ry_value, 16'h0000);
    tick();
    reg_wr = 1'b0;
    check("rdw_after_rx", Rx_value, 16'hBEEF);
    check("rdw_after_ry", Ry_value, 16'hBEEF);

    // R0 is writable; R15 is reachable.
    do_write(4'd0, 16'hFFFF);
    do_write(4'd15, 16'h8001);
    read_both(4'd0, 4'd15);
    check("r0_writable", Rx_value, 16'hFFFF);
    check("r15_top", Ry_value, 16'h8001);

    // Consecutive writes to the same register leave the last value.
    do_write(4'd6, 16'h1111);
    do_write(4'd6, 16'h2222);
    read_both(4'd6, 4'd2);
    check("same_addr_last", Rx_value, 16'h2222);
    check("same_addr_r2_intact", Ry_value, 16'h5555);

    // Reset beats a simultaneous write and clears everything.
    reset      = 1'b1;
    reg_wr     = 1'b1;
    addr_Rz    = 4'd4;
    write_data = 16'hCAFE;
    tick();
    reset  = 1'b0;
    reg_wr = 1'b0;
    read_both(4'd4, 4'd1);
    check("rst_vs_wr_r4", Rx_value, 16'h0000);
    check("rst_clr_r1", Ry_value, 16'h0000);
    read_both(4'd2, 4'd5);
    check("rst_clr_r2", Rx_value, 16'h0000);
    check("rst_clr_r5", Ry_value, 16'h0000);
    read_both(4'd0, 4'd15);
    check("rst_clr_r0", Rx_value, 16'h0000);
    check("rst_clr_r15", Ry_value, 16'h0000);
    read_both(4'd6, 4'd6);
    check("rst_clr_r6", Rx_value, 16'h0000);

    // Writes resume on the first edge with reset low.
    do_write(4'd4, 16'hCAFE);
    read_both(4'd4, 4'd3);
    check("resume_r4", Rx_value, 16'hCAFE);
    check("resume_r3_zero", Ry_value, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_register_file
